// File: rtl/synapse_row_fetch_master_pkg.sv
// Shared constants, FSM encoding and beat address helper for the synapse row fetch master
// and the synapse matrix slave address decode.
package synapse_row_fetch_master_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h3000_0000;
    localparam int unsigned WORDS_PER_ROW     = 8;
    localparam int unsigned ROW_BYTES         = 32;
    localparam int unsigned WORD_BYTES        = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    // Byte address of one beat: base + axon row offset + word offset, 32-bit wraparound.
    function automatic logic [31:0] beat_addr(input logic [31:0] base,
                                              input logic [7:0]  axon,
                                              input logic [7:0]  beat);
        return base + 32'(axon) * 32'(ROW_BYTES) + 32'(beat) * 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/synapse_row_fetch_master_if.sv
// Wishbone classic read-initiator bus between the row fetch master and the synapse matrix slave.
interface synapse_row_fetch_master_if;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );

endinterface

// File: rtl/synapse_row_fetch_master.sv
// Fetches one axon row from the synapse matrix with single-word Wishbone reads and hands
// the assembled row to the neuron core over valid/ready.
module synapse_row_fetch_master #(
    parameter logic [31:0] BASE_ADDR     = synapse_row_fetch_master_pkg::BASE_ADDR_DEFAULT,
    parameter int unsigned WORDS_PER_ROW = synapse_row_fetch_master_pkg::WORDS_PER_ROW,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [7:0]                    req_axon_i,
    output logic                          row_valid_o,
    input  logic                          row_ready_i,
    output logic [32*WORDS_PER_ROW-1:0]   row_data_o,
    output logic [7:0]                    row_axon_o,
    output logic [1:0]                    weight_select_o,
    output logic                          err_o,
    output logic                          busy_o,
    synapse_row_fetch_master_if.master    wbm
);
    import synapse_row_fetch_master_pkg::*;

    localparam int unsigned       BEAT_W    = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam int unsigned       ROW_W     = 32 * WORDS_PER_ROW;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_ROW - 1);
    localparam logic [15:0]       TMO_LAST  = 16'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [15:0]        tmo_q, tmo_d;
    logic [31:0]        adr_q, adr_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [7:0]         axon_q, axon_d;
    logic               err_q, err_d;
    logic               cyc_q, busy_q, row_valid_q, req_ready_q;

    // Next-state, beat sequencing, row assembly and timeout detection.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        tmo_d   = tmo_q;
        adr_d   = adr_q;
        row_d   = row_q;
        axon_d  = axon_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    axon_d  = req_axon_i;
                    beat_d  = '0;
                    tmo_d   = 16'd0;
                    row_d   = '0;
                    adr_d   = beat_addr(BASE_ADDR, req_axon_i, 8'd0);
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (wbm.wbm_ack_i) begin
                    row_d[32*int'(beat_q) +: 32] = wbm.wbm_dat_i;
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_HOLD;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = S_GAP;
                    end
                end else if (tmo_q >= TMO_LAST) begin
                    // Abandon the row; the consumer never sees a partial one.
                    err_d   = 1'b1;
                    tmo_d   = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_GAP: begin
                // Strobe drops here so the slave's held ack cannot be counted twice.
                tmo_d   = 16'd0;
                adr_d   = beat_addr(BASE_ADDR, axon_q, 8'(beat_q));
                state_d = S_REQ;
            end
            S_HOLD: begin
                if (row_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered output flags.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            tmo_q       <= 16'd0;
            adr_q       <= 32'd0;
            row_q       <= '0;
            axon_q      <= 8'd0;
            err_q       <= 1'b0;
            cyc_q       <= 1'b0;
            busy_q      <= 1'b0;
            row_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            tmo_q       <= tmo_d;
            adr_q       <= adr_d;
            row_q       <= row_d;
            axon_q      <= axon_d;
            err_q       <= err_d;
            cyc_q       <= (state_d == S_REQ);
            busy_q      <= (state_d != S_IDLE);
            row_valid_q <= (state_d == S_HOLD);
            req_ready_q <= (state_d == S_IDLE);
        end
    end

    assign wbm.wbm_cyc_o   = cyc_q;
    assign wbm.wbm_stb_o   = cyc_q;
    assign wbm.wbm_we_o    = 1'b0;
    assign wbm.wbm_sel_o   = 4'b1111;
    assign wbm.wbm_adr_o   = adr_q;
    assign wbm.wbm_dat_o   = 32'h0000_0000;

    assign req_ready_o     = req_ready_q;
    assign row_valid_o     = row_valid_q;
    assign row_data_o      = row_q;
    assign row_axon_o      = axon_q;
    assign weight_select_o = {1'b0, axon_q[0]};
    assign err_o           = err_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_synapse_row_fetch_master.sv
// Randomized bench for synapse_row_fetch_master: Wishbone slave model with wait states,
// stray acks and a stall address, checked against a row/address reference model.
module tb_synapse_row_fetch_master;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          TMO  = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready;
    logic [7:0]   req_axon;
    logic         row_valid, row_ready;
    logic [255:0] row_data;
    logic [7:0]   row_axon;
    logic [1:0]   wsel;
    logic         err, busy;

    synapse_row_fetch_master_if wb();

    synapse_row_fetch_master #(.TIMEOUT(TMO)) u_dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_axon_i      (req_axon),
        .row_valid_o     (row_valid),
        .row_ready_i     (row_ready),
        .row_data_o      (row_data),
        .row_axon_o      (row_axon),
        .weight_select_o (wsel),
        .err_o           (err),
        .busy_o          (busy),
        .wbm             (wb)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Synapse matrix contents and slave model knobs.
    logic [31:0] mem [0:2047];
    logic [31:0] stall_adr = 32'hFFFF_FFFF;
    int          max_wait  = 0;
    bit          stray_en  = 1'b0;
    logic        slv_ack_q = 1'b0;
    logic [31:0] slv_dat_q = 32'd0;
    int          slv_wait_q = 0;
    logic        stray_q = 1'b0;
    logic [10:0] slv_idx;

    assign slv_idx      = 11'((wb.wbm_adr_o - BASE) >> 2);
    assign wb.wbm_ack_i = slv_ack_q | (stray_q & ~wb.wbm_cyc_o);
    assign wb.wbm_dat_i = slv_ack_q ? slv_dat_q : 32'hDEAD_BEEF;

    // Slave: ack after a random wait, held while cyc&stb stay high.
    always @(posedge clk) begin
        stray_q <= stray_en ? ($urandom_range(0, 2) == 0) : 1'b0;
        if (!(wb.wbm_cyc_o && wb.wbm_stb_o)) begin
            slv_ack_q  <= 1'b0;
            slv_wait_q <= (max_wait > 0) ? int'($urandom_range(0, max_wait)) : 0;
        end else if (wb.wbm_adr_o == stall_adr) begin
            slv_ack_q <= 1'b0;
        end else if (slv_wait_q == 0) begin
            slv_ack_q <= 1'b1;
            slv_dat_q <= mem[slv_idx];
        end else begin
            slv_wait_q <= slv_wait_q - 1;
        end
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_adr(input logic [7:0] axon, input int k);
        return BASE + 32'(axon) * 32'd32 + 32'(k) * 32'd4;
    endfunction

    // One fetch: optional hold with ready low, optional stall (timeout), optional reset at a beat.
    task automatic run_fetch(input logic [7:0] axon, input int hold, input bit expect_to,
                             input int rst_beat);
        logic [31:0]  seen[$];
        logic [255:0] exp_row;
        int  n, gap_n, stb_run, err_n, idle_n;
        bit  prev_stb, got_row, hit_rst;
        for (int k = 0; k < 8; k++) exp_row[32*k +: 32] = mem[int'(axon)*8 + k];
        row_ready = (hold == 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_axon  = axon;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_ready_wait", req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_axon  = 8'($urandom);
        check_eq("busy_after_accept", busy, 1'b1);
        gap_n = 0; stb_run = 0; err_n = 0; idle_n = 0;
        prev_stb = 1'b1; got_row = 1'b0; hit_rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (err) err_n++;
            if (req_ready) idle_n++;
            if (wb.wbm_stb_o) begin
                if (!prev_stb) begin
                    check_eq("gap_len", gap_n, 1);
                    gap_n = 0;
                end
                stb_run++;
                if (rst_beat >= 0 && seen.size() == rst_beat) begin
                    hit_rst = 1'b1;
                    break;
                end
                if (wb.wbm_ack_i) begin
                    seen.push_back(wb.wbm_adr_o);
                    stb_run = 0;
                end
            end else if (seen.size() > 0 && seen.size() < 8) begin
                gap_n++;
            end
            prev_stb = wb.wbm_stb_o;
            if (row_valid) begin
                got_row = 1'b1;
                break;
            end
            if (idle_n == 3) break;
            @(negedge clk);
        end
        for (int k = 0; k < seen.size(); k++) check_eq("beat_adr", seen[k], exp_adr(axon, k));

        if (rst_beat >= 0) begin
            check_eq("rst_reached", hit_rst, 1'b1);
            rst = 1'b1;
            @(posedge clk);
            #1;
            check_eq("rst_cyc", wb.wbm_cyc_o, 1'b0);
            check_eq("rst_stb", wb.wbm_stb_o, 1'b0);
            check_eq("rst_busy", busy, 1'b0);
            check_eq("rst_row_data", row_data, 256'd0);
            check_eq("rst_row_valid", row_valid, 1'b0);
            check_eq("rst_err", err, 1'b0);
            @(negedge clk);
            rst = 1'b0;
            check_eq("rst_req_ready", req_ready, 1'b1);
        end else if (expect_to) begin
            check_eq("to_no_row", got_row, 1'b0);
            check_eq("to_err_pulses", err_n, 1);
            check_eq("to_req_cycles", stb_run, TMO);
            check_eq("to_beats_done", seen.size(), 2);
            check_eq("to_req_ready", req_ready, 1'b1);
            check_eq("to_cyc_low", wb.wbm_cyc_o, 1'b0);
        end else begin
            check_eq("row_seen", got_row, 1'b1);
            check_eq("beat_count", seen.size(), 8);
            check_eq("row_data", row_data, exp_row);
            check_eq("row_axon", row_axon, axon);
            check_eq("weight_sel", wsel, {1'b0, axon[0]});
            check_eq("no_err", err_n, 0);
            check_eq("hold_cyc_low", wb.wbm_cyc_o, 1'b0);
            for (int h = 0; h < hold; h++) begin
                req_valid = 1'b1;
                req_axon  = 8'($urandom);
                @(negedge clk);
                check_eq("hold_valid", row_valid, 1'b1);
                check_eq("hold_data", row_data, exp_row);
                check_eq("hold_axon", row_axon, axon);
                check_eq("hold_req_ready", req_ready, 1'b0);
            end
            req_valid = 1'b0;
            row_ready = 1'b1;
            @(negedge clk);
            check_eq("release_valid", row_valid, 1'b0);
            check_eq("release_req_ready", req_ready, 1'b1);
            check_eq("release_busy", busy, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        for (int k = 0; k < 8; k++) mem[k] = 32'hA0 + 32'(k);
        rst = 1'b1; req_valid = 1'b0; req_axon = 8'd0; row_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_cyc", wb.wbm_cyc_o, 1'b0);
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_row_valid", row_valid, 1'b0);
        check_eq("reset_err", err, 1'b0);
        check_eq("reset_adr", wb.wbm_adr_o, 32'd0);
        check_eq("reset_row_data", row_data, 256'd0);
        check_eq("reset_req_ready", req_ready, 1'b1);
        rst = 1'b0;

        run_fetch(8'd0, 0, 1'b0, -1);
        run_fetch(8'd3, 0, 1'b0, -1);
        run_fetch(8'd5, 10, 1'b0, -1);
        stall_adr = exp_adr(8'd7, 2);
        run_fetch(8'd7, 0, 1'b1, -1);
        stall_adr = 32'hFFFF_FFFF;
        max_wait = 2;
        run_fetch(8'd9, 0, 1'b0, 5);
        run_fetch(8'd255, 0, 1'b0, -1);
        stray_en = 1'b1;
        run_fetch(8'd1, 0, 1'b0, -1);
        run_fetch(8'd2, 0, 1'b0, -1);
        max_wait = 5;
        for (int r = 0; r < 20; r++) begin
            run_fetch(8'($urandom), int'($urandom_range(0, 3)), 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
